// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: operand word, op codes, FSM states.
package muldiv_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;

  // State names carry an ST_ prefix because MD_DIV is already an op code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  localparam int MD_ITERS = 32;

  function automatic word_t abs_if(input word_t v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module div_iter
  import muldiv_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  step,
  input  word_t dividend,
  input  word_t divisor,
  output word_t quotient,
  output word_t remainder
);

  word_t       rem_q;
  word_t       quo_q;
  word_t       dvs_q;
  logic [32:0] shifted;

  // Partial remainder shifted left with the next dividend bit (33 bits).
  assign shifted = {rem_q, quo_q[31]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      // shifted - divisor < divisor here, so the low 32 bits are exact.
      if (shifted >= {1'b0, dvs_q}) begin
        rem_q <= shifted[31:0] - dvs_q;
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_FAST_MUL_EN for a
// single-cycle multiply (IDLE -> FIX); division stays iterative in both builds.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      a,
  input  word_t      b,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo
);

  muldiv_state_t state, state_n;
  logic [5:0]    count;
  logic [63:0]   acc;
  logic [63:0]   mul_mag;
  word_t         mcand;
  word_t         a_raw;
  word_t         quo;
  word_t         rem;
  logic          neg_q;
  logic          neg_r;
  logic          div_zero;
  logic          is_div;
  logic          accept;
  logic          is_mul_op;
  logic          is_div_op;
  logic          sgn_op;
  logic          last_iter;

  assign is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign sgn_op    = (op == MD_MULT) || (op == MD_DIV);
  assign accept    = start && (state == ST_IDLE);
  assign last_iter = (count == 6'(MD_ITERS - 1));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
          state_n = ST_FIX;
`else
          state_n = ST_MUL;
`endif
        end else if (accept && is_div_op) begin
          state_n = ST_DIV;
        end
      end
      ST_MUL:  if (last_iter) state_n = ST_FIX;
      ST_DIV:  if (last_iter) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_mag = {32'b0, mcand} * {32'b0, acc[31:0]};
`else
  logic [32:0] add_sum;
  logic [63:0] acc_step;
  // Shift-add: add multiplicand into the upper half when the LSB is set, then shift.
  assign add_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'b0)};
  assign acc_step = {add_sum, acc[31:1]};
  assign mul_mag  = acc;
`endif

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (reset),
    .load      (accept && is_div_op),
    .step      (state == ST_DIV),
    .dividend  (abs_if(a, sgn_op)),
    .divisor   (abs_if(b, sgn_op)),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && (is_mul_op || is_div_op)) begin
        count    <= '0;
        mcand    <= abs_if(a, sgn_op);
        acc      <= {32'b0, abs_if(b, sgn_op)};
        a_raw    <= a;
        neg_q    <= sgn_op && (a[31] ^ b[31]);
        neg_r    <= sgn_op && a[31];
        div_zero <= is_div_op && (b == '0);
        is_div   <= is_div_op;
      end
      if (accept && op == MD_MTHI) hi <= a;
      if (accept && op == MD_MTLO) lo <= a;
      case (state)
        ST_MUL: begin
`ifndef MULDIV_FAST_MUL_EN
          acc <= acc_step;
`endif
          count <= count + 6'd1;
        end
        ST_DIV: count <= count + 6'd1;
        ST_FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_q ? -mul_mag : mul_mag;
          end else if (div_zero) begin
            // Divide by zero returns the dividend untouched, quotient all ones.
            hi <= a_raw;
            lo <= 32'hFFFF_FFFF;
          end else begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: per-cycle model compare plus literal checks.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  muldiv_op_t op;
  word_t      a, b;
  logic       busy, done;
  word_t      hi, lo;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  // Reference model: architectural HI/LO plus a countdown to the result write.
  word_t m_hi, m_lo, p_hi, p_lo;
  int    m_left;
  logic  m_done;
  logic  m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_result(input muldiv_op_t o, input word_t x, input word_t y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT:  return 64'(sx * sy);
      MD_MULTU: return {32'b0, x} * {32'b0, y};
      MD_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'b0;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0; m_done = 0;
    end else begin
      m_idle = (m_left == 0);
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end
      if (m_idle && start) begin
        case (op)
          MD_MULT, MD_MULTU: begin {p_hi, p_lo} = ref_result(op, a, b); m_left = MUL_LAT; end
          MD_DIV, MD_DIVU:   begin {p_hi, p_lo} = ref_result(op, a, b); m_left = DIV_LAT; end
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input muldiv_op_t o, input word_t x, input word_t y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_cmp++; n_err++;
    $display("FAIL idle_timeout: busy still 1 after 100 cycles");
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no done pulse within 100 cycles");
    end
  endtask

  task automatic run_lit(input string nm, input muldiv_op_t o, input word_t x, input word_t y,
                         input word_t eh, input word_t el);
    int lat;
    wait_idle();
    issue(o, x, y);
    wait_done(lat);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  function automatic word_t rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return word_t'($urandom_range(0, 15));
      default: return word_t'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; op = MD_NONE; a = '0; b = '0;
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1; reset = 1'b0;

    // Test 1: signed multiply and its latency.
    wait_idle();
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    chk("mult_latency", 32'(lat), 32'(MUL_LAT + 1));
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_lit("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_lit("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_lit("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_lit("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_lit("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_lit("div_zero_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Test 5: a DIVU issued mid-multiply must be dropped.
    wait_idle();
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0001);
    if (MUL_LAT > 1) begin
      repeat (8) @(posedge clk);
      #1; start = 1'b1; op = MD_DIVU; a = 32'd7; b = 32'd2;
      @(posedge clk); #1; start = 1'b0; op = MD_NONE;
    end
    wait_done(lat);
    chk("mid_hi", hi, 32'h0000_0001);
    chk("mid_lo", lo, 32'h0001_0000);
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h0);

    wait_idle();
    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", 32'(busy), 32'h0);

    // Test 6: reset in the middle of a divide.
    issue(MD_MTLO, 32'h0000_5555, 32'h0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    run_lit("post_rst_mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Random traffic, including starts while busy and in the done cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      op = muldiv_op_t'($urandom_range(0, 6));
      a = rnd_opnd();
      b = rnd_opnd();
    end
    @(posedge clk); #1; start = 1'b0; op = MD_NONE;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
